spiflash_reader: RTL and testbench
==================================

# spiflash_reader

SPI flash read controller (initiator) for the SoC boot/instruction path. Accepts 32-bit word read requests on a simple req/ready interface and runs a single-lane mode-0 SPI READ (0x03) transaction: 8-bit command, 24-bit address, then 32 data bits. It returns the assembled little-endian word with a one-cycle valid pulse. It connects to the `spiflash_model` pins: `cs_n`, `clk`, `dq[0]` as MOSI and `dq[1]` as MISO. Top level leaves `dq[3:2]` undriven/pulled.

## Interface
- `CLK_DIV`, default 1: system clocks per SCLK half-period; legal ≥1.
- `READ_CMD`, default 8'h03: command byte sent first.
- `clk` input 1: system clock; all logic on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req_i` input 1: read request; accepted when `req_i && ready_o` at a rising edge.
- `addr_i` input 24: flash byte address; sampled at acceptance; no alignment required.
- `ready_o` output 1: controller idle and able to accept.
- `rvalid_o` output 1: one-cycle pulse, `rdata_o` valid.
- `rdata_o` output 32: read word; holds until next completion.
- `spi_cs_n_o` output 1: chip select, active low.
- `spi_sclk_o` output 1: SPI clock, idles low (mode 0).
- `spi_mosi_o` output 1: to `dq[0]`.
- `spi_miso_i` input 1: from `dq[1]`.

## Operation
- FSM states are IDLE, SETUP, SHIFT, HOLD, DONE.
- **IDLE**
  - `ready_o`=1, `cs_n`=1, `sclk`=0, `mosi`=0.
  - On acceptance, load the 32-bit out-shifter with `{READ_CMD, addr_i}`, clear the bit counter (6 bits, 0..63), and go to SETUP.
- **SETUP** (CLK_DIV cycles)
  - `cs_n`=0, `sclk`=0, `mosi`=out-shifter[31] (command MSB).
- **SHIFT**: 64 SCLK periods. Each period is CLK_DIV cycles with `sclk`=0, then CLK_DIV cycles with `sclk`=1.
  - Rising SCLK (low→high register update): if bit counter ≥32, shift `spi_miso_i` into the in-shifter.
  - Falling SCLK (high→low update): bit counter +1, shift the out-shifter left and fill with 0.
  - `mosi` is out-shifter[31] throughout. During data bits (counter ≥32), `mosi`=0.
  - After the 64th falling edge, go to HOLD.
- **HOLD** (CLK_DIV cycles): `cs_n`=0, `sclk`=0.
- **DONE** (1 cycle)
  - `cs_n`=1, `rvalid_o`=1, `rdata_o` updated.
  - Next state is IDLE.
- **Bit and byte ordering**
  - MSB first on the wire, both directions.
  - Received byte k (k=0..3, in arrival order, from address addr_i+k) goes to `rdata_o[8k+7:8k]`.
- **Request handling and reset**
  - `req_i` while `ready_o`=0 is ignored; the request is not queued.
  - Reset values: `ready_o`=1, `rvalid_o`=0, `rdata_o`=0, `spi_cs_n_o`=1, `spi_sclk_o`=0, `spi_mosi_o`=0; state is IDLE.
  - Reset mid-transaction aborts: `cs_n` goes high in the cycle after reset is sampled, with no `rvalid_o` pulse and `rdata_o` cleared.
- All SPI outputs are registered; no combinational path from `spi_miso_i` to any output.

## Timing
- Acceptance edge is cycle 0. `spi_cs_n_o` is low for cycles 1..130·CLK_DIV, i.e. exactly 130·CLK_DIV cycles.
- `rvalid_o` is high in cycle 130·CLK_DIV+1, which is the first cycle `cs_n` is high again. `ready_o` rises in cycle 130·CLK_DIV+2.
- With CLK_DIV=1: 131 cycles request-to-data; SCLK period 2 clocks.
- Back-to-back: `cs_n` is high for at least 2 cycles between transactions (DONE + IDLE acceptance cycle). The model resets on the `cs_n` rising edge.
- **MISO sampling margin**
  - The flash drives MISO on the SCLK falling edge.
  - The controller samples it CLK_DIV system cycles later, at the next rising update.
  - The first data bit is sampled at the 33rd SCLK rise.
- `mosi` changes only together with SCLK falling updates, or at SETUP entry. It is stable for the full SCLK-high phase.

## Test plan
1. **Read addr 0, CLK_DIV=1.**
   - Preload model with 37 05 00 10 93 05 a0 0a 23 22 b5 00 6f 00 00 00; req addr 0x000000.
   - Required: `rdata_o`=0x10000537 with `rvalid_o` at cycle 131.
   - Bench captures MOSI at the first 32 SCLK rises = 0x03000000.
   - Exactly 64 SCLK rising edges while `cs_n` is low.
2. **Back-to-back reads.**
   - Stimulus: addr 0x000004 then 0x000008, with `req_i` held high.
   - Required: 0x0aa00593 then 0x00b52223, with `cs_n` high ≥2 cycles between transactions.
3. **CLK_DIV=4, addr 0x00000C.**
   - Required: `rdata_o`=0x0000006f, `cs_n` low 520 cycles, SCLK high/low 4 cycles each, `rvalid_o` at cycle 521.
4. **Unaligned address.**
   - Stimulus: addr 0x000002.
   - Required: `rdata_o`=0x05931000.
5. **Out-of-range and busy requests.**
   - Stimulus: addr 0x000400 (model returns zero); toggle `req_i` with another address during the transfer.
   - Required: `rdata_o`=0x00000000, a single `rvalid_o` pulse, and the busy-time request is ignored.
6. **Reset mid-shift.**
   - Stimulus: assert `rst` for 1 cycle at SCLK bit 40.
   - Required: `cs_n`=1 and `sclk`=0 in the next cycle, no `rvalid_o`, `rdata_o`=0.
   - A following read of addr 0 returns 0x10000537.

Source files
------------

// File: rtl/spiflash_reader.sv
// spiflash_reader: single-lane mode-0 SPI flash READ controller returning little-endian 32-bit words
module spiflash_reader #(
  parameter int CLK_DIV = 1,
  parameter logic [7:0] READ_CMD = 8'h03
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic [23:0] addr_i,
  output logic        ready_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        spi_cs_n_o,
  output logic        spi_sclk_o,
  output logic        spi_mosi_o,
  input  logic        spi_miso_i
);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_t;
  state_t state;
  logic [DW-1:0] div;
  logic [5:0] bit_cnt;
  logic [31:0] sh_out;
  logic [31:0] sh_in;
  logic tick;
  assign tick = div == DIV_MAX;
  assign spi_mosi_o = sh_out[31];
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      div <= '0;
      bit_cnt <= '0;
      sh_out <= '0;
      sh_in <= '0;
      ready_o <= 1'b1;
      rvalid_o <= 1'b0;
      rdata_o <= '0;
      spi_cs_n_o <= 1'b1;
      spi_sclk_o <= 1'b0;
    end else begin
      rvalid_o <= 1'b0;
      div <= (state == IDLE || tick) ? '0 : div + 1'b1;
      case (state)
        IDLE: if (req_i) begin
          state <= SETUP;
          ready_o <= 1'b0;
          spi_cs_n_o <= 1'b0;
          sh_out <= {READ_CMD, addr_i};
          bit_cnt <= '0;
        end
        SETUP: if (tick) state <= SHIFT;
        SHIFT: if (tick) begin
          spi_sclk_o <= !spi_sclk_o;
          if (!spi_sclk_o && bit_cnt[5]) sh_in <= {sh_in[30:0], spi_miso_i};
          if (spi_sclk_o) begin
            bit_cnt <= bit_cnt + 1'b1;
            sh_out <= {sh_out[30:0], 1'b0};
            if (&bit_cnt) state <= HOLD;
          end
        end
        HOLD: if (tick) begin
          state <= DONE;
          spi_cs_n_o <= 1'b1;
          rvalid_o <= 1'b1;
          rdata_o <= {sh_in[7:0], sh_in[15:8], sh_in[23:16], sh_in[31:24]};
        end
        default: begin
          state <= IDLE;
          ready_o <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_spiflash_reader.sv
// tb_spiflash_reader: randomized scoreboard bench with a behavioural SPI flash model on two controllers
module tb_spiflash_reader;
  typedef struct {int id; logic [31:0] w; int c;} exp_t;
  localparam logic [7:0] BOOT [16] = '{8'h37, 8'h05, 8'h00, 8'h10, 8'h93, 8'h05, 8'ha0, 8'h0a,
                                       8'h23, 8'h22, 8'hb5, 8'h00, 8'h6f, 8'h00, 8'h00, 8'h00};
  logic clk = 1'b0;
  logic [1:0] rst, req, ready, rvalid, cs_n, sclk, mosi, miso, rst_d, pc, ps;
  logic [23:0] addr [2];
  logic [31:0] rdata [2];
  logic [7:0] mem [1024];
  exp_t q[$];
  exp_t e;
  int checks = 0, errors = 0, cyc = 0;
  int rises [2], run [2], lo [2], hi [2];
  bit seen [2];
  logic [31:0] sr [2];
  logic [23:0] last_addr [2];
  int d, k, want;
  logic [7:0] byt;

  spiflash_reader #(.CLK_DIV(1)) dut0 (
    .clk(clk), .rst(rst[0]), .req_i(req[0]), .addr_i(addr[0]), .ready_o(ready[0]),
    .rvalid_o(rvalid[0]), .rdata_o(rdata[0]), .spi_cs_n_o(cs_n[0]), .spi_sclk_o(sclk[0]),
    .spi_mosi_o(mosi[0]), .spi_miso_i(miso[0]));
  spiflash_reader #(.CLK_DIV(4)) dut1 (
    .clk(clk), .rst(rst[1]), .req_i(req[1]), .addr_i(addr[1]), .ready_o(ready[1]),
    .rvalid_o(rvalid[1]), .rdata_o(rdata[1]), .spi_cs_n_o(cs_n[1]), .spi_sclk_o(sclk[1]),
    .spi_mosi_o(mosi[1]), .spi_miso_i(miso[1]));

  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    rst_d <= rst;
  end

  function automatic logic [7:0] b(input int a);
    return (a >= 0 && a < 1024) ? mem[a] : 8'h00;
  endfunction
  function automatic logic [31:0] ref_word(input logic [23:0] a);
    int x;
    x = int'({8'h00, a});
    return {b(x + 3), b(x + 2), b(x + 1), b(x)};
  endfunction
  function automatic void chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, act, exp_v);
    end
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      d = (i == 1) ? 4 : 1;
      if (rst_d[i]) begin
        chk(cs_n[i] == 1'b1, "rst_cs_n", 32'(cs_n[i]), 1);
        chk(sclk[i] == 1'b0, "rst_sclk", 32'(sclk[i]), 0);
        chk(mosi[i] == 1'b0, "rst_mosi", 32'(mosi[i]), 0);
        chk(ready[i] == 1'b1, "rst_ready", 32'(ready[i]), 1);
        chk(rvalid[i] == 1'b0, "rst_rvalid", 32'(rvalid[i]), 0);
        chk(rdata[i] == 32'h0, "rst_rdata", rdata[i], 0);
        miso[i] = 1'b0;
        hi[i] = 2;
      end else if (!cs_n[i]) begin
        if (pc[i]) begin
          if (seen[i]) chk(hi[i] >= 2, "cs_gap", hi[i], 2);
          seen[i] = 1'b1;
          lo[i] = 0;
          rises[i] = 0;
          run[i] = 0;
          sr[i] = '0;
        end
        lo[i]++;
        if (sclk[i] && !ps[i]) begin
          want = (rises[i] == 0) ? 2 * d : d;
          chk(run[i] == want, "sclk_low_len", run[i], want);
          if (rises[i] < 32) sr[i] = {sr[i][30:0], mosi[i]};
          else chk(mosi[i] == 1'b0, "mosi_in_data", 32'(mosi[i]), 0);
          rises[i]++;
          run[i] = 0;
        end else if (!sclk[i] && ps[i]) begin
          chk(run[i] == d, "sclk_high_len", run[i], d);
          k = rises[i] - 32;
          if (k < 0) miso[i] = 1'($urandom);
          else begin
            byt = b(int'({8'h00, sr[i][23:0]}) + k / 8);
            miso[i] = byt[7 - k % 8];
          end
          run[i] = 0;
        end
        run[i]++;
      end else begin
        if (!pc[i]) begin
          chk(lo[i] == 130 * d, "cs_low_len", lo[i], 130 * d);
          chk(rises[i] == 64, "sclk_rises", rises[i], 64);
          chk(sr[i] == {8'h03, last_addr[i]}, "mosi_cmd_addr", sr[i], {8'h03, last_addr[i]});
          hi[i] = 0;
          miso[i] = 1'b0;
        end
        hi[i]++;
      end
      if (rvalid[i] && !rst_d[i]) begin
        if (q.size() == 0) chk(1'b0, "unexpected_rvalid", rdata[i], 0);
        else begin
          e = q.pop_front();
          chk(e.id == i, "rvalid_port", i, e.id);
          chk(rdata[i] == e.w, "rdata", rdata[i], e.w);
          chk(cyc - e.c == 130 * d + 1, "latency", cyc - e.c, 130 * d + 1);
        end
      end
      pc[i] = cs_n[i];
      ps[i] = sclk[i];
    end
  end

  task automatic issue(input int id, input logic [23:0] a, input bit hold);
    int n = 0;
    @(negedge clk);
    req[id] = 1'b1;
    addr[id] = a;
    while (!ready[id] && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!ready[id]) chk(1'b0, "ready_timeout", 32'(ready[id]), 1);
    else begin
      last_addr[id] = a;
      q.push_back('{id, ref_word(a), cyc});
    end
    @(negedge clk);
    if (!hold) req[id] = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while ((q.size() != 0 || ready != 2'b11) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) chk(1'b0, "done_timeout", q.size(), 0);
  endtask

  initial begin
    int n;
    rst = 2'b11;
    req = 2'b00;
    miso = 2'b00;
    addr[0] = '0;
    addr[1] = '0;
    last_addr[0] = '0;
    last_addr[1] = '0;
    for (int j = 0; j < 1024; j++) mem[j] = 8'($urandom);
    for (int j = 0; j < 16; j++) mem[j] = BOOT[j];
    repeat (3) @(negedge clk);
    rst = 2'b00;
    issue(0, 24'h000000, 1'b0);
    wait_done();
    issue(0, 24'h000004, 1'b1);
    issue(0, 24'h000008, 1'b0);
    wait_done();
    issue(1, 24'h00000C, 1'b0);
    wait_done();
    issue(0, 24'h000002, 1'b0);
    wait_done();
    issue(0, 24'h000400, 1'b0);
    repeat (3) begin
      repeat (10) @(negedge clk);
      req[0] = 1'b1;
      addr[0] = 24'h000010;
      repeat (5) @(negedge clk);
      req[0] = 1'b0;
    end
    wait_done();
    repeat (20) @(negedge clk);
    for (int j = 0; j < 8; j++) issue(0, 24'($urandom_range(0, 1100)), j != 7);
    wait_done();
    for (int j = 0; j < 2; j++) begin
      issue(1, 24'($urandom_range(990, 1030)), 1'b0);
      wait_done();
    end
    issue(0, 24'h000000, 1'b0);
    @(negedge clk);
    n = 0;
    while (rises[0] < 40 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) chk(1'b0, "bit40_timeout", rises[0], 40);
    rst[0] = 1'b1;
    void'(q.pop_back());
    @(negedge clk);
    rst[0] = 1'b0;
    repeat (200) @(negedge clk);
    issue(0, 24'h000000, 1'b0);
    wait_done();
    repeat (5) @(negedge clk);
    chk(q.size() == 0, "queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout got=%0d want=done", cyc);
    $fatal(1);
  end
endmodule
